// File: rtl/cla_slice_sequencer_pkg.sv
// Shared types and constants for the sliced carry-lookahead adder/subtractor.
package cla_slice_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_SLICE = 8;

    // Slice index width: clog2(N), never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cla_slice_sequencer_if.sv
// Start/done handshake and operand/result bus between the ALU stage and the sequencer.
interface cla_slice_sequencer_if
    import cla_slice_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, op1, op2,
        input  ready, done, result, cout, ovf
    );

    modport slave (
        input  start, sub, op1, op2,
        output ready, done, result, cout, ovf
    );
endinterface

// File: rtl/cla_slice_sequencer_net.sv
// Combinational lookahead carry network for one SLICE-bit group.
module cla_slice_net #(
    parameter int unsigned SLICE = 8
) (
    input  logic [SLICE-1:0] i_a,
    input  logic [SLICE-1:0] i_b,
    input  logic             i_cin,
    output logic [SLICE-1:0] o_sum,
    output logic             o_cout,
    output logic             o_c_top
);
    logic [SLICE-1:0] w_g;
    logic [SLICE-1:0] w_p;
    logic [SLICE:0]   w_c;

    assign w_g = i_a & i_b;
    assign w_p = i_a | i_b;

    // Each carry is the flattened sum of products g[j]&p[j+1..i] | cin&p[0..i].
    always_comb begin : carry_tree
        logic w_prop;
        logic w_gen;
        w_c    = '0;
        w_prop = 1'b1;
        w_gen  = 1'b0;
        w_c[0] = i_cin;
        for (int unsigned i = 0; i < SLICE; i++) begin
            w_prop = 1'b1;
            w_gen  = 1'b0;
            for (int unsigned k = 0; k <= i; k++) begin
                w_gen  = w_gen | (w_g[i-k] & w_prop);
                w_prop = w_prop & w_p[i-k];
            end
            w_c[i+1] = w_gen | (i_cin & w_prop);
        end
    end

    assign o_sum   = i_a ^ i_b ^ w_c[SLICE-1:0];
    assign o_cout  = w_c[SLICE];
    assign o_c_top = w_c[SLICE-1];
endmodule

// File: rtl/cla_slice_sequencer.sv
// Multi-cycle adder/subtractor: resolves one SLICE-bit group per clock with start/done handshake.
module cla_slice_sequencer
    import cla_slice_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned SLICE = DEF_SLICE
) (
    input  logic                   clk,
    input  logic                   rst,
    cla_slice_sequencer_if.slave   bus
);
    localparam int unsigned         N        = WIDTH / SLICE;
    localparam int unsigned         IDX_W    = idx_width(N);
    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(N - 1);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_result;
    logic [IDX_W-1:0] r_idx;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovf;
    logic             r_done;

    logic [SLICE-1:0] w_a_slice;
    logic [SLICE-1:0] w_b_slice;
    logic [SLICE-1:0] w_sum;
    logic             w_slice_cout;
    logic             w_c_top;
    logic             w_accept;
    logic             w_last;
    logic [WIDTH-1:0] w_mask;
    logic [WIDTH-1:0] w_ins;

    assign w_accept  = bus.start && (r_state != ST_RUN);
    assign w_last    = (r_idx == LAST_IDX);
    assign w_a_slice = SLICE'(r_a >> (r_idx * SLICE));
    assign w_b_slice = SLICE'(r_b >> (r_idx * SLICE));
    assign w_mask    = WIDTH'({SLICE{1'b1}}) << (r_idx * SLICE);
    assign w_ins     = WIDTH'(w_sum) << (r_idx * SLICE);

    cla_slice_net #(.SLICE(SLICE)) u_net (
        .i_a     (w_a_slice),
        .i_b     (w_b_slice),
        .i_cin   (r_carry),
        .o_sum   (w_sum),
        .o_cout  (w_slice_cout),
        .o_c_top (w_c_top)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (bus.start) w_next = ST_RUN;
            ST_RUN:  if (w_last)    w_next = ST_DONE;
            ST_DONE: w_next = bus.start ? ST_RUN : ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_idx    <= '0;
            r_carry  <= 1'b0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= (w_next == ST_DONE);
            if (w_accept) begin
                r_a      <= bus.op1;
                r_b      <= bus.sub ? ~bus.op2 : bus.op2;
                r_carry  <= bus.sub;
                r_idx    <= '0;
                r_result <= '0;
            end else if (r_state == ST_RUN) begin
                r_result <= (r_result & ~w_mask) | w_ins;
                r_carry  <= w_slice_cout;
                r_idx    <= r_idx + 1'b1;
                if (w_last) begin
                    r_cout <= w_slice_cout;
                    r_ovf  <= w_slice_cout ^ w_c_top;
                end
            end
        end
    end

    assign bus.ready  = (r_state != ST_RUN);
    assign bus.done   = r_done;
    assign bus.result = r_result;
    assign bus.cout   = r_cout;
    assign bus.ovf    = r_ovf;
endmodule

// File: tb/tb_cla_slice_sequencer.sv
// Self-checking bench: directed vector table, multi-cycle handshake corner cases, random ops vs arithmetic model.
module tb_cla_slice_sequencer;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    cla_slice_sequencer_if #(.WIDTH(32)) bus();

    cla_slice_sequencer #(.WIDTH(32), .SLICE(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sub;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] exp_res;
        logic        exp_cout;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain signed/unsigned integer arithmetic.
    task automatic model(input logic s, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic co, output logic ov);
        longint sa;
        longint sb;
        longint ss;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ss  = s ? (sa - sb) : (sa + sb);
        res = s ? (a - b) : (a + b);
        co  = s ? (a >= b) : ((33'(a) + 33'(b)) >> 32);
        ov  = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
    endtask

    task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic co, output logic ov,
                          output int lat, output int rlow);
        bit seen;
        seen = 0;
        lat  = -1;
        rlow = 0;
        res  = '0;
        co   = 1'b0;
        ov   = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.sub   = s;
        bus.op1   = a;
        bus.op2   = b;
        for (int c = 1; c <= 20 && !seen; c++) begin
            @(negedge clk);
            if (c == 1) bus.start = 1'b0;
            if (!bus.ready) rlow++;
            if (bus.done) begin
                seen = 1;
                lat  = c - 1;
                res  = bus.result;
                co   = bus.cout;
                ov   = bus.ovf;
            end
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL op_timeout: got no done expected done within 20 cycles");
        end else begin
            @(negedge clk);
            check("done_one_cycle", 64'(bus.done), 64'd0);
            check("result_hold", 64'(bus.result), 64'(res));
        end
    endtask

    initial begin
        logic [31:0] res;
        logic [31:0] mres;
        logic        co;
        logic        ov;
        logic        mco;
        logic        mov;
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        int          rlow;
        int          e;
        int          dcount;
        int          d1;
        int          d2;

        n_cmp = 0;
        n_bad = 0;
        vecs[0] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1};
        vecs[4] = '{1'b0, 32'h0000_0003, 32'h0000_0004, 32'h0000_0007, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1};

        rst = 1'b1;
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.op1   = '0;
        bus.op2   = '0;
        @(negedge clk);
        check("rst_ready", 64'(bus.ready), 64'd1);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_result", 64'(bus.result), 64'd0);
        check("rst_cout", 64'(bus.cout), 64'd0);
        check("rst_ovf", 64'(bus.ovf), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].sub, vecs[i].op1, vecs[i].op2, res, co, ov, lat, rlow);
            check("vec_result", 64'(res), 64'(vecs[i].exp_res));
            check("vec_cout", 64'(co), 64'(vecs[i].exp_cout));
            check("vec_ovf", 64'(ov), 64'(vecs[i].exp_ovf));
            check("vec_latency", 64'(lat), 64'd4);
            check("vec_ready_low", 64'(rlow), 64'd4);
        end

        // Start pulsed mid-RUN must be dropped, not queued.
        @(negedge clk);
        bus.start = 1'b1;
        bus.sub   = 1'b0;
        bus.op1   = 32'h1234_5678;
        bus.op2   = 32'h1111_1111;
        @(negedge clk);
        bus.start = 1'b0;
        check("busy_ready", 64'(bus.ready), 64'd0);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op1   = 32'h1;
        bus.op2   = 32'h1;
        @(negedge clk);
        bus.start = 1'b0;
        e = 2;
        while (!bus.done && e < 20) begin
            @(negedge clk);
            e++;
        end
        check("ignore_latency", 64'(e), 64'd4);
        check("ignore_result", 64'(bus.result), 64'h2345_6789);
        dcount = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.done) dcount++;
        end
        check("ignore_no_extra_done", 64'(dcount), 64'd0);
        check("ignore_result_kept", 64'(bus.result), 64'h2345_6789);

        // Reset two edges into an operation aborts it.
        @(negedge clk);
        bus.start = 1'b1;
        bus.op1   = 32'hAAAA_0000;
        bus.op2   = 32'h5555_0000;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_result", 64'(bus.result), 64'd0);
        check("abort_ready", 64'(bus.ready), 64'd1);
        check("abort_done", 64'(bus.done), 64'd0);
        check("abort_cout", 64'(bus.cout), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        dcount = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.done) dcount++;
        end
        check("abort_no_done", 64'(dcount), 64'd0);
        run_op(1'b0, 32'd3, 32'd4, res, co, ov, lat, rlow);
        check("after_abort_result", 64'(res), 64'd7);
        check("after_abort_latency", 64'(lat), 64'd4);

        // Start held high through DONE: back-to-back accept.
        @(negedge clk);
        bus.start = 1'b1;
        bus.sub   = 1'b0;
        bus.op1   = 32'd10;
        bus.op2   = 32'd20;
        d1 = -1;
        d2 = -1;
        for (int c = 1; c <= 20 && d2 < 0; c++) begin
            @(negedge clk);
            if (c == 1) begin
                bus.op1 = 32'hFFFF_0000;
                bus.op2 = 32'h0000_FFFF;
            end
            if (bus.done) begin
                if (d1 < 0) begin
                    d1 = c;
                    check("b2b_first", 64'(bus.result), 64'd30);
                end else begin
                    d2 = c;
                    check("b2b_second", 64'(bus.result), 64'hFFFF_FFFF);
                    bus.start = 1'b0;
                end
            end
        end
        bus.start = 1'b0;
        check("b2b_first_at", 64'(d1), 64'd5);
        check("b2b_spacing", 64'(d2 - d1), 64'd5);
        @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            b = $urandom;
            if (i % 8 == 0) a = 32'h8000_0000;
            if (i % 8 == 1) b = a;
            model(s, a, b, mres, mco, mov);
            run_op(s, a, b, res, co, ov, lat, rlow);
            check("rand_result", 64'(res), 64'(mres));
            check("rand_cout", 64'(co), 64'(mco));
            check("rand_ovf", 64'(ov), 64'(mov));
            check("rand_latency", 64'(lat), 64'd4);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1);
    end
endmodule

// File: doc/cla_slice_sequencer.md
# cla_slice_sequencer

Multi-cycle adder/subtractor for the MIPS pipeline ALU. It consumes per-bit generate/propagate terms (g = a&b, p = a|b) and resolves carries with a lookahead network, one SLICE-bit group per clock. The carry between slices is held in a register. Start/done handshaking lets the ALU stage stall the pipeline while a wide operation completes.

## Interface
Parameters:
- WIDTH, 32, operand/result width; must be a multiple of SLICE
- SLICE, 8, bits resolved per clock; N = WIDTH/SLICE run cycles

Ports:
- clk  input  1  clock, rising-edge
- rst  input  1  reset, asynchronous, active-high
- start  input  1  request; accepted only when ready=1
- sub  input  1  1 = op1 − op2, 0 = op1 + op2; sampled with start
- op1  input  WIDTH  first operand; sampled with start
- op2  input  WIDTH  second operand; sampled with start
- ready  output  1  block can accept start (state ≠ RUN)
- done  output  1  one-cycle pulse: result valid
- result  output  WIDTH  sum/difference; held until the next accepted start
- cout  output  1  carry out of bit WIDTH−1 (for sub: 1 = no borrow)
- ovf  output  1  signed overflow = c[WIDTH] ^ c[WIDTH−1]

## Operation
- States: IDLE, RUN, DONE.
- Reset (async, any state): state=IDLE, slice index=0, carry reg=0, result=0, cout=0, ovf=0, done=0, ready=1.
- Accept (start=1 in IDLE or DONE):
  - latch A=op1 and B=sub ? ~op2 : op2
  - carry reg=sub, index=0, state=RUN, result cleared to 0
- start while in RUN is ignored; it is not queued.
- Each RUN edge, for slice k = index:
  - per bit: g=a&b, p=a|b
  - c[i+1]=g[i] | (p[i]&c[i]); the slice carry-in is the carry reg
  - sum bit = a^b^c[i]
  - write result[k*SLICE +: SLICE]; carry reg = slice carry-out; index++
- Last slice (index=N−1):
  - also register cout=c[WIDTH] and ovf=c[WIDTH]^c[WIDTH−1]
  - state=DONE
- DONE: done=1 for exactly one cycle. The next edge goes to IDLE, or to RUN if start=1.
- Arithmetic is modulo 2^WIDTH. With sub=1 the result is op1 + ~op2 + 1.

## Timing
- Edge 0: start accepted. Edges 1..N: slices 0..N−1 resolved. done is high from edge N to edge N+1.
- Latency is N cycles from the accept edge to done rising; default N=4.
- Back-to-back: start held high in DONE is accepted at edge N+1, giving a throughput of one operation per N+1 cycles.
- ready is low from edge 0 through edge N, exactly the RUN interval.
- result, cout and ovf are stable from done rising until the next accept edge.
- Partial result bits are visible during RUN and are not guaranteed valid.
- Reset mid-RUN aborts immediately. No done is produced for the aborted operation.
- Outputs are registered; no combinational path from inputs to outputs except ready, which decodes state only.

## Structure
- Shared package holds:
  - the state enum {IDLE, RUN, DONE}
  - the default WIDTH/SLICE constants
  - a localparam function for the index width, clog2(N), minimum 1
- One natural sub-module, `cla_slice_net`, which is combinational:
  - inputs: SLICE-bit a and b, carry-in
  - outputs: SLICE-bit sum, carry-out, and the carry into the top bit (for ovf)
- The sequencer holds the FSM, operand registers, carry register, index counter and result register.

## Test plan
- Add 0xFFFFFFFF + 0x00000001 → result 0x00000000, cout=1, ovf=0; done high only between edges 4 and 5.
- Add 0x7FFFFFFF + 0x00000001 → result 0x80000000, cout=0, ovf=1.
- Sub 5 − 7 → result 0xFFFFFFFE, cout=0, ovf=0. Sub 0x80000000 − 1 → result 0x7FFFFFFF, cout=1, ovf=1.
- Pulse start with 1+1 during RUN of 0x12345678+0x11111111 → second request ignored; result 0x23456789, ready low for 4 cycles.
- Assert rst after edge 2 of an add → result=0, done never pulses, ready=1. A following 3+4 yields 7 with done after 4 cycles.
- start held high across DONE with 10+20 then 0xFFFF0000+0x0000FFFF → results 30 then 0xFFFFFFFF, done pulses 5 cycles apart.
